// File: rtl/cacheline_mem_initiator.sv
// Initiator-side controller for the 256-bit cacheline memory interface: turns one miss
// request into an optional victim writeback followed by an optional line fill.
module cacheline_mem_initiator #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_wb,
    input  logic         req_fill,
    input  logic [26:0]  req_wb_addr,
    input  logic [255:0] req_wb_data,
    input  logic [26:0]  req_fill_addr,
    output logic         done,
    output logic [255:0] fill_data,
    output logic         error,
    output logic [31:0]  mem_addr,
    output logic         mem_read,
    output logic         mem_write,
    output logic [255:0] mem_wdata,
    input  logic [255:0] mem_rdata,
    input  logic         mem_resp
);

    localparam int unsigned LINE_W = 256;
    localparam int unsigned TAG_W  = 27;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned OFF_W  = 5;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WB,
        S_FILL,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [LINE_W-1:0]   fill_data_q, fill_data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                fill_q, fill_d;
    logic [TAG_W-1:0]    fill_addr_q, fill_addr_d;

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        error_d     = error_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        fill_data_d = fill_data_q;
        cnt_d       = cnt_q;
        fill_d      = fill_q;
        fill_addr_d = fill_addr_q;

        case (state_q)
            S_IDLE: begin
                if (mem_resp) begin
                    error_d = 1'b1;
                end
                if (req_valid && ready_q) begin
                    fill_d      = req_fill;
                    fill_addr_d = req_fill_addr;
                    cnt_d       = '0;
                    if (req_wb) begin
                        state_d     = S_WB;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {req_wb_addr, {OFF_W{1'b0}}};
                        mem_wdata_d = req_wb_data;
                    end else if (req_fill) begin
                        state_d    = S_FILL;
                        mem_read_d = 1'b1;
                        mem_addr_d = {req_fill_addr, {OFF_W{1'b0}}};
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_WB, S_FILL: begin
                if (mem_resp) begin
                    cnt_d = '0;
                    if (state_q == S_FILL) begin
                        fill_data_d = mem_rdata;
                    end
                    // Writeback hands straight over to the fill with no idle cycle.
                    if (state_q == S_WB && fill_q) begin
                        state_d     = S_FILL;
                        mem_write_d = 1'b0;
                        mem_read_d  = 1'b1;
                        mem_addr_d  = {fill_addr_q, {OFF_W{1'b0}}};
                    end else begin
                        state_d     = S_DONE;
                        mem_write_d = 1'b0;
                        mem_read_d  = 1'b0;
                    end
                end else if (cnt_q != CNT_W'(TIMEOUT)) begin
                    // Saturating wait counter; control stays asserted after timeout.
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        error_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (mem_resp) begin
                    error_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            fill_data_q <= '0;
            cnt_q       <= '0;
            fill_q      <= 1'b0;
            fill_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            error_q     <= error_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            fill_data_q <= fill_data_d;
            cnt_q       <= cnt_d;
            fill_q      <= fill_d;
            fill_addr_q <= fill_addr_d;
        end
    end

    assign req_ready = ready_q;
    assign done      = done_q;
    assign error     = error_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign fill_data = fill_data_q;

endmodule

// File: doc/cacheline_mem_initiator.md
# cacheline_mem_initiator

Initiator-side controller for the 256-bit cacheline memory interface: mem_read/mem_write/mem_addr/mem_wdata out, mem_resp/mem_rdata in. It sits between the cache miss-handling logic and the memory responder. It turns one upstream miss request into an optional victim writeback followed by an optional line fill, and holds address, control and write data stable until each response. It captures the fill line and reports completion, with a response timeout and protocol-error flag.

## Interface
- TIMEOUT, 1024: cycles an operation may wait for mem_resp before error is raised; must be ≥ 2.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  upstream request valid.
- req_ready  out  1  high exactly when state is IDLE.
- req_wb  in  1  request includes victim writeback.
- req_fill  in  1  request includes line fill.
- req_wb_addr  in  27  victim line address [31:5].
- req_wb_data  in  256  victim line data.
- req_fill_addr  in  27  fill line address [31:5].
- done  out  1  one-cycle pulse; request complete.
- fill_data  out  256  captured fill line; valid from the done cycle until the next fill is captured.
- error  out  1  sticky protocol/timeout error.
- mem_addr  out  32  line address, bits [4:0] always 0.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_wdata  out  256  write data.
- mem_rdata  in  256  read data; valid only in the mem_resp cycle.
- mem_resp  in  1  one-cycle response pulse from the responder.

## Operation
- States: IDLE, WB, FILL, DONE.
- IDLE, req_valid high: latch all req_* fields.
  - req_wb=1: go to WB.
  - req_wb=0, req_fill=1: go to FILL.
  - Both 0: go to DONE, with no memory traffic.
- WB: mem_write=1, mem_addr={wb_addr,5'b0}, mem_wdata=latched wb data. On mem_resp: go to FILL if req_fill=1, otherwise DONE.
- FILL: mem_read=1, mem_addr={fill_addr,5'b0}. On mem_resp: fill_data<=mem_rdata, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- All memory-side outputs are registered. mem_read and mem_write are never high together. mem_addr, control and mem_wdata do not change while an operation is outstanding, including the mem_resp cycle.
- mem_wdata holds its value after a write completes and is not required to be cleared.
- Timeout:
  - A counter clears on entry to WB or FILL and increments every cycle mem_resp=0.
  - On reaching TIMEOUT, error<=1. The state does not change, and control stays asserted so the protocol is not violated.
- mem_resp=1 while in IDLE or DONE: error<=1, response ignored.
- error clears only on rst.

## Timing
- Reset values:
  - req_ready=0 during the rst cycle and 1 after.
  - done=0, error=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, fill_data=0, timeout counter=0, state IDLE.
- Request accepted at edge E, when req_valid and req_ready are both high. mem_write or mem_read goes high in cycle E+1.
- Cycle R is the cycle in which mem_resp=1. Outputs stay unchanged through cycle R, so the responder sees control still asserted there.
- At the end of R:
  - WB→FILL: mem_write<=0, mem_read<=1, mem_addr<=fill address. The read is visible in R+1, with no idle gap.
  - WB→DONE or FILL→DONE: control<=0. done=1 in R+1. req_ready=1 in R+2.
- Request with no wb and no fill: done is in the cycle after acceptance.
- Minimum spacing: a new request accepted at the end of R+2 drives control in R+3. The responder has been idle since the end of R.
- rst mid-operation: control drops in the next cycle and no done is produced. The responder shares rst.
- The timeout counter saturates at TIMEOUT; it does not wrap.

## Test plan
- Fill only. Responder with DELAY=10 preloaded: line 0x0000_1000 = 256'hA5…A5. Request fill_addr=0x80.
  - Expect mem_read high from acceptance+1 until the resp cycle, mem_addr=0x0000_1000, mem_write=0.
  - Expect done one cycle after resp, fill_data=A5…A5, error=0.
- Writeback+fill. wb_addr=0x100 with data 256'h1234…, fill_addr=0x101.
  - Expect the write to 0x0000_2000 held through its resp cycle.
  - Expect mem_read at 0x0000_2020 in the very next cycle.
  - Expect a later fill of 0x2000 to return 256'h1234….
- Writeback only (req_fill=0). Expect exactly one write, done at R+1, mem_read never asserted.
- Null request (req_wb=0, req_fill=0). Expect done the cycle after acceptance, mem_read and mem_write stay 0.
- Timeout. TIMEOUT=16, responder tied mem_resp=0.
  - Expect error=1 exactly 16 cycles after mem_read rises, mem_read still 1.
  - Expect rst to clear error and mem_read next cycle.
- Spurious response. Pulse mem_resp while IDLE. Expect error=1 and no state change. Back-to-back requests with DELAY=2 run with no responder $error.
